custom_axi_lite_master: RTL and testbench
=========================================

CUSTOM_AXI_LITE_MASTER -- requirements
Module: custom_axi_lite_master
Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: width of the request address and of m_axi_awaddr/m_axi_araddr.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32: width of the write/read data; the strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  in  1  a command is offered.
REQ-006 SHALL have port req_ready_o  out  1  the command can be accepted.
REQ-007 SHALL have port req_we_i  in  1  1=write, 0=read.
REQ-008 SHALL have port req_addr_i  in  AXI_ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata_i  in  AXI_DATA_WIDTH  write data.
REQ-010 SHALL have port req_wstrb_i  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid_o  out  1  the response is valid.
REQ-012 SHALL have port rsp_ready_i  in  1  the requester accepts the response.
REQ-013 SHALL have port rsp_rdata_o  out  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp_o  out  2  the captured BRESP or RRESP.
REQ-015 SHALL have port m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
REQ-016 SHALL have port m_axi_awvalid  out  1  write address valid.
REQ-017 SHALL have port m_axi_awready  in  1  write address ready.
REQ-018 SHALL have port m_axi_wdata  out  AXI_DATA_WIDTH  write data.
REQ-019 SHALL have port m_axi_wstrb  out  AXI_DATA_WIDTH/8  write strobes.
REQ-020 SHALL have port m_axi_wvalid  out  1  write data valid.
REQ-021 SHALL have port m_axi_wready  in  1  write data ready.
REQ-022 SHALL have port m_axi_bresp  in  2  write response.
REQ-023 SHALL have port m_axi_bvalid  in  1  write response valid.
REQ-024 SHALL have port m_axi_bready  out  1  write response ready.
REQ-025 SHALL have port m_axi_araddr  out  AXI_ADDR_WIDTH  read address.
REQ-026 SHALL have port m_axi_arvalid  out  1  read address valid.
REQ-027 SHALL have port m_axi_arready  in  1  read address ready.
REQ-028 SHALL have port m_axi_rdata  in  AXI_DATA_WIDTH  read data.
REQ-029 SHALL have port m_axi_rresp  in  2  read response.
REQ-030 SHALL have port m_axi_rvalid  in  1  read data valid.
REQ-031 SHALL have port m_axi_rready  out  1  read data ready.
Function
REQ-032 SHALL implement the FSM states IDLE, WR_AW_W, WR_B, RD_AR, RD_R and RSP, with at most one transaction outstanding.
REQ-033 SHALL assert req_ready_o only in IDLE; on req_valid_i&&req_ready_o it SHALL capture we/addr/wdata/wstrb and go to WR_AW_W (we=1) or RD_AR (we=0).
REQ-034 SHALL drive every m_axi_* output from a register; no valid SHALL depend combinationally on any ready, and payloads SHALL stay stable while their valid is high.
REQ-035 SHALL, in WR_AW_W, assert awvalid and wvalid together from the cycle after accept, drop each one alone in the cycle after its own handshake, and go to WR_B once both handshakes are done (same-cycle or in either order).
REQ-036 SHALL, in WR_B, hold bready=1; on bvalid it SHALL capture bresp, set rsp_rdata_o=0 and go to RSP.
REQ-037 SHALL, in RD_AR, hold arvalid=1 until arready; then in RD_R it SHALL hold rready=1, capture rdata/rresp on rvalid and go to RSP.
REQ-038 SHALL, in RSP, hold rsp_valid_o=1 with rsp_rdata_o/rsp_resp_o stable until rsp_ready_i, then go to IDLE; no new command SHALL be accepted in that same cycle.
REQ-039 SHALL have minimum latencies (ready/valid always high): write accept at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid_o at cycle 3; read accept at 0, AR at 1, R at 2, rsp_valid_o at 3.
REQ-040 SHALL pass address and strobes unmodified (unaligned address or wstrb=0 still issued); SLVERR/DECERR SHALL be reported only through rsp_resp_o.
REQ-041 SHALL ignore bvalid/rvalid outside WR_B/RD_R.
Reset
REQ-042 SHALL, on a clock edge with rst_ni=0, go to IDLE and drive every output to 0, req_ready_o included; req_ready_o SHALL be 1 in the first cycle after release.
REQ-043 SHALL, on reset mid-transaction, abandon it without a response; the AXI slave is reset in the same domain.
Verification
REQ-044 SHALL be verified with: write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, slave always ready, bresp=OKAY -> AW/W at cycle 1, rsp_valid_o at cycle 3, rsp_resp_o=0, rsp_rdata_o=0.
REQ-045 SHALL be verified with: write, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held with stable awaddr until its handshake, then B phase.
REQ-046 SHALL be verified with: read addr=0x20, slave returns 0x12345678 with rresp=SLVERR -> rsp_rdata_o=0x12345678, rsp_resp_o=2.
REQ-047 SHALL be verified with: rsp_ready_i held low for 5 cycles -> rsp held stable, req_ready_o=0 throughout, IDLE re-entered the cycle after rsp_ready_i.
REQ-048 SHALL be verified with: rst_ni low for 1 cycle while in WR_B -> all valids/readies 0 the next cycle, req_ready_o=1 after release, no rsp_valid_o.

Source files
------------

// File: rtl/custom_axi_lite_master.sv
// custom_axi_lite_master: turns single request/response commands into AXI4-Lite
// write or read transactions, with at most one transaction outstanding.
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   req_valid_i/req_ready_o     command handshake (req_ready_o only in IDLE)
//   req_we_i, req_addr_i,       command: direction, byte address,
//   req_wdata_i, req_wstrb_i    write data and byte strobes
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_resp_o     read data (0 for writes), captured BRESP/RRESP
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master channels, all outputs registered
module custom_axi_lite_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                  rsp_resp_o,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic [1:0]                resp_q, resp_d;
    logic                      req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                      arvalid_q, arvalid_d, rready_q, rready_d;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_q) begin
                addr_d    = req_addr_i;
                wdata_d   = req_wdata_i;
                wstrb_d   = req_wstrb_i;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_we_i ? WR_AW_W : RD_AR;
            end
            WR_AW_W: begin
                // AW and W complete independently; leave once both are done
                aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
                w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
                state_d   = (aw_done_d && w_done_d) ? WR_B : WR_AW_W;
            end
            WR_B: if (bready_q && m_axi_bvalid) begin
                resp_d  = m_axi_bresp;
                rdata_d = '0;
                state_d = RSP;
            end
            RD_AR: state_d = (arvalid_q && m_axi_arready) ? RD_R : RD_AR;
            RD_R: if (rready_q && m_axi_rvalid) begin
                resp_d  = m_axi_rresp;
                rdata_d = m_axi_rdata;
                state_d = RSP;
            end
            RSP: state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
        // Every handshake output is registered from the next state, so no valid
        // ever depends combinationally on a ready.
        req_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR_AW_W) && !aw_done_d;
        wvalid_d    = (state_d == WR_AW_W) && !w_done_d;
        bready_d    = (state_d == WR_B);
        arvalid_d   = (state_d == RD_AR);
        rready_d    = (state_d == RD_R);
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_resp_o    = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_custom_axi_lite_master.sv
// tb_custom_axi_lite_master: table-driven and randomized checks of the AXI-Lite master
// against a latency/response model, plus hand-written reset sequences.
module tb_custom_axi_lite_master;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata = '0;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready = 1'b0, m_axi_wvalid, m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic        m_axi_bvalid = 1'b0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1'b0;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    custom_axi_lite_master dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                                logic [1:0] resp, logic [31:0] rdata, int aw, int w, int b,
                                int ar, int r, int rs, int exp_cyc, logic [31:0] exp_rdata,
                                logic [1:0] exp_resp);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.resp = resp; v.rdata = rdata;
        v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r; v.rsp_dly = rs;
        v.exp_cyc = exp_cyc; v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
        return v;
    endfunction

    // Reference model: the first rsp_valid_o cycle (accept = cycle 0) follows from
    // the slave delays; each channel adds one registered cycle after the previous phase.
    function automatic int model_rsp_cyc(vec_t v);
        int aw_hs = 1 + v.aw_dly;
        int w_hs  = 1 + v.w_dly;
        int ar_hs = 1 + v.ar_dly;
        if (v.we) return ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + v.b_dly + 1;
        return ar_hs + 1 + v.r_dly + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Plays requester and AXI slave for one command; called and returns at a negedge.
    task automatic run_txn(input vec_t v, input string tag);
        int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
        int awc = 0, wc = 0, arc = 0, bc = 0, rc = 0, rspc = 0;
        int aw_hs = -1, w_hs = -1, ar_hs = -1, rsp_first = -1, rsp_acc = -1;
        logic aw_done = 0, w_done = 0, ar_done = 0, b_sent = 0, r_sent = 0;
        logic bad_pay = 0, bad_ready = 0, bad_stable = 0, got = 0;
        logic aw_now, w_now, ar_now;
        logic [31:0] first_rdata = '0;
        logic [1:0]  first_resp = '0;
        check({tag, ".req_ready_idle"}, req_ready_o, 1);
        req_valid_i = 1; req_we_i = v.we; req_addr_i = v.addr;
        req_wdata_i = v.wdata; req_wstrb_i = v.wstrb;
        // Stray response valids on the unused channel must be ignored.
        if (v.we) begin m_axi_rvalid = 1; m_axi_rdata = 32'hBAD0BAD0; m_axi_rresp = 2'b11; end
        else begin m_axi_bvalid = 1; m_axi_bresp = 2'b11; end
        for (int cyc = 0; cyc < 80 && !got; cyc++) begin
            if (cyc == 1) begin
                // Keep offering a different command; it must not be taken until IDLE.
                req_we_i = ~v.we; req_addr_i = ~v.addr; req_wdata_i = ~v.wdata;
            end
            if (cyc >= 1 && req_ready_o) bad_ready = 1;
            if (v.we) begin
                m_axi_bvalid = aw_done && w_done && !b_sent && bc >= v.b_dly;
                m_axi_bresp = v.resp;
                if (aw_done && w_done && !b_sent && bc < v.b_dly) bc++;
                if (m_axi_bvalid && m_axi_bready) begin b_n++; b_sent = 1; end
            end else begin
                m_axi_rvalid = ar_done && !r_sent && rc >= v.r_dly;
                m_axi_rdata = v.rdata; m_axi_rresp = v.resp;
                if (ar_done && !r_sent && rc < v.r_dly) rc++;
                if (m_axi_rvalid && m_axi_rready) begin r_n++; r_sent = 1; end
            end
            aw_now = 0; w_now = 0; ar_now = 0;
            if (m_axi_awvalid) begin
                if (m_axi_awaddr !== v.addr) bad_pay = 1;
                m_axi_awready = awc >= v.aw_dly;
                if (m_axi_awready) begin aw_n++; aw_hs = cyc; aw_now = 1; end else awc++;
            end else m_axi_awready = 0;
            if (m_axi_wvalid) begin
                if (m_axi_wdata !== v.wdata || m_axi_wstrb !== v.wstrb) bad_pay = 1;
                m_axi_wready = wc >= v.w_dly;
                if (m_axi_wready) begin w_n++; w_hs = cyc; w_now = 1; end else wc++;
            end else m_axi_wready = 0;
            if (m_axi_arvalid) begin
                if (m_axi_araddr !== v.addr) bad_pay = 1;
                m_axi_arready = arc >= v.ar_dly;
                if (m_axi_arready) begin ar_n++; ar_hs = cyc; ar_now = 1; end else arc++;
            end else m_axi_arready = 0;
            if (rsp_valid_o) begin
                if (rsp_first < 0) begin
                    rsp_first = cyc; first_rdata = rsp_rdata_o; first_resp = rsp_resp_o;
                end else if (rsp_rdata_o !== first_rdata || rsp_resp_o !== first_resp) bad_stable = 1;
                rsp_ready_i = rspc >= v.rsp_dly;
                if (rsp_ready_i) begin got = 1; rsp_acc = cyc; end else rspc++;
            end else rsp_ready_i = 0;
            aw_done = aw_done | aw_now;
            w_done = w_done | w_now;
            ar_done = ar_done | ar_now;
            tick();
        end
        req_valid_i = 0; rsp_ready_i = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s.timeout: no response accepted within 80 cycles", tag);
            rst_ni = 0; tick(); rst_ni = 1; tick();
        end else begin
            check({tag, ".rsp_cycle"}, rsp_first, v.exp_cyc);
            check({tag, ".rsp_accept_cycle"}, rsp_acc, v.exp_cyc + v.rsp_dly);
            check({tag, ".rsp_rdata"}, first_rdata, v.exp_rdata);
            check({tag, ".rsp_resp"}, first_resp, v.exp_resp);
            check({tag, ".rsp_stable"}, bad_stable, 0);
            check({tag, ".req_ready_busy"}, bad_ready, 0);
            check({tag, ".axi_payload"}, bad_pay, 0);
            check({tag, ".idle_after"}, {req_ready_o, rsp_valid_o}, 2'b10);
            if (v.we) begin
                check({tag, ".hs_counts"}, {aw_n[3:0], w_n[3:0], b_n[3:0], ar_n[3:0]}, 16'h1110);
                check({tag, ".aw_cycle"}, aw_hs, 1 + v.aw_dly);
                check({tag, ".w_cycle"}, w_hs, 1 + v.w_dly);
            end else begin
                check({tag, ".hs_counts"}, {ar_n[3:0], r_n[3:0], aw_n[3:0], w_n[3:0]}, 16'h1100);
                check({tag, ".ar_cycle"}, ar_hs, 1 + v.ar_dly);
            end
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, 32'h0, 0, 0, 0, 0, 0, 0, 3, 32'h0, 2'd0);
        tbl[1] = mk(1, 32'h44, 32'h01020304, 4'h5, 2'd0, 32'h0, 3, 0, 0, 0, 0, 0, 6, 32'h0, 2'd0);
        tbl[2] = mk(0, 32'h20, 32'h0, 4'h0, 2'd2, 32'h12345678, 0, 0, 0, 0, 0, 0, 3, 32'h12345678, 2'd2);
        tbl[3] = mk(0, 32'h30, 32'h0, 4'h0, 2'd0, 32'hCAFE0001, 0, 0, 0, 0, 0, 5, 3, 32'hCAFE0001, 2'd0);
        tbl[4] = mk(1, 32'h13, 32'h55AA55AA, 4'h0, 2'd3, 32'h0, 0, 2, 0, 0, 0, 0, 5, 32'h0, 2'd3);
        tbl[5] = mk(0, 32'h1001, 32'h0, 4'h0, 2'd3, 32'hA5A50F0F, 0, 0, 0, 2, 3, 0, 8, 32'hA5A50F0F, 2'd3);
        tbl[6] = mk(1, 32'hFFFFFFFC, 32'h11223344, 4'hC, 2'd2, 32'h0, 1, 1, 2, 0, 0, 1, 6, 32'h0, 2'd2);

        // Power-up reset: every output is 0 while reset is held.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset.handshakes", {req_ready_o, rsp_valid_o, m_axi_awvalid, m_axi_wvalid,
              m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check("reset.payloads", {rsp_rdata_o, rsp_resp_o, m_axi_awaddr, m_axi_wdata,
              m_axi_wstrb, m_axi_araddr}, 0);
        rst_ni = 1;
        tick();
        check("reset.release_ready", req_ready_o, 1);

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting in WR_B: transaction abandoned, no response.
        req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h80; req_wdata_i = 32'h0BADF00D; req_wstrb_i = 4'hF;
        m_axi_awready = 1; m_axi_wready = 1;
        tick();
        req_valid_i = 0;
        check("midrst.aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        tick();
        m_axi_awready = 0; m_axi_wready = 0;
        check("midrst.in_wr_b", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
        rst_ni = 0;
        tick();
        check("midrst.outputs_cleared", {req_ready_o, rsp_valid_o, m_axi_awvalid, m_axi_wvalid,
              m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        rst_ni = 1;
        tick();
        check("midrst.release_ready", req_ready_o, 1);
        begin
            logic seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (rsp_valid_o || m_axi_bready || !req_ready_o) seen = 1;
                tick();
            end
            check("midrst.no_response", seen, 0);
        end

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.we = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.wstrb = 4'($urandom_range(0, 15)); v.resp = 2'($urandom_range(0, 3));
            v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
            v.b_dly = $urandom_range(0, 3); v.ar_dly = $urandom_range(0, 3);
            v.r_dly = $urandom_range(0, 3); v.rsp_dly = $urandom_range(0, 3);
            v.exp_cyc = model_rsp_cyc(v);
            v.exp_rdata = v.we ? 32'h0 : v.rdata;
            v.exp_resp = v.resp;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
